// File: rtl/picorv32_soc_rst_seq_if.sv
// Reset sequencer bus: soft-reset sources in, reset/status back out.
interface picorv32_soc_rst_seq_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 hps_rst_req;
  logic                 key_rst_n;
  logic                 soc_rst;
  logic                 running;
  logic [2:0]           rst_cause;
  logic [CNT_WIDTH-1:0] rst_count;

  // Reset requester / status reader side (HPS PIO, KEY, test harness)
  modport master (
    output hps_rst_req, key_rst_n,
    input  soc_rst, running, rst_cause, rst_count
  );

  // Sequencer side
  modport slave (
    input  hps_rst_req, key_rst_n,
    output soc_rst, running, rst_cause, rst_count
  );
endinterface

// File: rtl/picorv32_soc_rst_seq.sv
// Reset sequencer for picorv32_wb_soc: merges POR, HPS and KEY reset sources,
// stretches the reset to a minimum hold time plus a release delay, and
// records the last reset cause and a saturating soft-reset count.
module picorv32_soc_rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int RELEASE_DLY = 64,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  picorv32_soc_rst_seq_if.slave        bus
);

  localparam int CMAX = (HOLD_CYCLES > RELEASE_DLY) ? HOLD_CYCLES : RELEASE_DLY;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(RELEASE_DLY - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  soc_rst_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  key_s;
  logic                  req;

  // KEY crosses from the 50 MHz domain; flops preset to "not pressed"
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_rst_n};
  end

  assign key_s = sync_q[SYNC_STAGES-1];
  // HPS request is already in wb_clk domain, so it is used unsynchronised
  assign req   = bus.hps_rst_req | ~key_s;

  // State, counters and registered reset output
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      cause_q   <= 3'b001;
      count_q   <= '0;
      soc_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
      // Registered from next state so soc_rst moves on the same edge as RUN entry/exit
      soc_rst_q <= (state_d != RUN);
    end
  end

  // Next-state logic: hold, wait for sources to drop, delay, run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    count_d = count_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = req ? WAIT : DELAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (req) begin
          // Restart of the sequence; not a new soft reset, so count untouched
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = {~key_s, bus.hps_rst_req, 1'b0};
        end else if (cnt_q == DLY_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = {~key_s, bus.hps_rst_req, 1'b0};
          if (count_q != '1) count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.soc_rst   = soc_rst_q;
  assign bus.running   = ~soc_rst_q;
  assign bus.rst_cause = cause_q;
  assign bus.rst_count = count_q;

endmodule

// File: tb/tb_picorv32_soc_rst_seq.sv
// Directed bench for the reset sequencer (HOLD=4, DLY=8, CNT_WIDTH=2).
// Inputs change and outputs are sampled on the falling edge of wb_clk.
module tb_picorv32_soc_rst_seq;
  localparam int HOLD = 4;
  localparam int DLY  = 8;
  localparam int CW   = 2;
  localparam int SS   = 2;

  logic wb_clk = 1'b0;
  logic wb_rst;
  int   errors = 0;
  int   checks = 0;

  picorv32_soc_rst_seq_if #(.CNT_WIDTH(CW)) bus ();

  picorv32_soc_rst_seq #(
    .HOLD_CYCLES(HOLD),
    .RELEASE_DLY(DLY),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS)
  ) u_dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .bus   (bus)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge
  task automatic step(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  initial begin
    wb_rst          = 1'b1;
    bus.hps_rst_req = 1'b0;
    bus.key_rst_n   = 1'b1;
    step(3);

    // 1. Power-on reset values, then release with no request
    chk("por_soc",     {31'b0, bus.soc_rst}, 32'd1);
    chk("por_running", {31'b0, bus.running}, 32'd0);
    chk("por_cause",   {29'b0, bus.rst_cause}, 32'd1);
    chk("por_count",   {30'b0, bus.rst_count}, 32'd0);
    wb_rst = 1'b0;
    step(11);
    chk("por_e11_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("por_e12_soc", {31'b0, bus.soc_rst}, 32'd0);
    chk("por_e12_run", {31'b0, bus.running}, 32'd1);
    chk("por_e12_cause", {29'b0, bus.rst_cause}, 32'd1);
    chk("por_e12_count", {30'b0, bus.rst_count}, 32'd0);

    // 2. Single-cycle HPS pulse in RUN
    step(2);
    bus.hps_rst_req = 1'b1;
    step(1);
    bus.hps_rst_req = 1'b0;
    chk("hps_soc",   {31'b0, bus.soc_rst}, 32'd1);
    chk("hps_cause", {29'b0, bus.rst_cause}, 32'd2);
    chk("hps_count", {30'b0, bus.rst_count}, 32'd1);
    step(11);
    chk("hps_e11_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("hps_e12_soc", {31'b0, bus.soc_rst}, 32'd0);

    // 5. Pulse during DELAY (count 5) restarts the whole 12-cycle sequence
    step(2);
    bus.hps_rst_req = 1'b1;
    step(1);
    bus.hps_rst_req = 1'b0;
    chk("rst5_count_a", {30'b0, bus.rst_count}, 32'd2);
    step(9);                          // HOLD 4 edges, DELAY count now 5
    bus.hps_rst_req = 1'b1;
    step(1);
    bus.hps_rst_req = 1'b0;
    chk("rst5_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(2);                          // unrestarted sequence would release here
    chk("rst5_orig_rel_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(9);
    chk("rst5_e11_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("rst5_e12_soc", {31'b0, bus.soc_rst}, 32'd0);
    chk("rst5_count_b", {30'b0, bus.rst_count}, 32'd2);

    // 3. HPS held for 50 cycles: WAIT keeps reset until req drops
    step(2);
    bus.hps_rst_req = 1'b1;
    step(1);
    chk("wait_soc",   {31'b0, bus.soc_rst}, 32'd1);
    chk("wait_count", {30'b0, bus.rst_count}, 32'd3);
    step(49);
    chk("wait_held_soc", {31'b0, bus.soc_rst}, 32'd1);
    bus.hps_rst_req = 1'b0;
    // one edge WAIT->DELAY, then DLY edges of DELAY
    step(8);
    chk("wait_rel8_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("wait_rel9_soc", {31'b0, bus.soc_rst}, 32'd0);

    // 4. KEY applied asynchronously, detected SYNC_STAGES+1 edges later
    step(2);
    @(negedge wb_clk);
    #2 bus.key_rst_n = 1'b0;
    step(2);
    chk("key_e2_soc", {31'b0, bus.soc_rst}, 32'd0);
    step(1);
    chk("key_e3_soc",   {31'b0, bus.soc_rst}, 32'd1);
    chk("key_cause",    {29'b0, bus.rst_cause}, 32'd4);
    chk("key_count_sat", {30'b0, bus.rst_count}, 32'd3);
    step(17);
    bus.key_rst_n = 1'b1;
    // 2 sync edges, 1 edge WAIT->DELAY, DLY edges of DELAY
    step(10);
    chk("key_rel10_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("key_rel11_soc", {31'b0, bus.soc_rst}, 32'd0);

    // 4b. HPS and KEY seen together
    step(2);
    bus.key_rst_n = 1'b0;
    step(2);
    chk("both_pre_soc", {31'b0, bus.soc_rst}, 32'd0);
    bus.hps_rst_req = 1'b1;
    step(1);
    bus.hps_rst_req = 1'b0;
    bus.key_rst_n   = 1'b1;
    chk("both_soc",   {31'b0, bus.soc_rst}, 32'd1);
    chk("both_cause", {29'b0, bus.rst_cause}, 32'd6);
    chk("both_count", {30'b0, bus.rst_count}, 32'd3);
    step(11);
    chk("both_e11_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("both_e12_soc", {31'b0, bus.soc_rst}, 32'd0);

    // 6. Power-on reset mid-DELAY aborts everything asynchronously
    step(2);
    bus.hps_rst_req = 1'b1;
    step(1);
    bus.hps_rst_req = 1'b0;
    step(6);
    #2 wb_rst = 1'b1;
    #1;
    chk("abort_soc",     {31'b0, bus.soc_rst}, 32'd1);
    chk("abort_running", {31'b0, bus.running}, 32'd0);
    chk("abort_count",   {30'b0, bus.rst_count}, 32'd0);
    chk("abort_cause",   {29'b0, bus.rst_cause}, 32'd1);
    step(2);
    wb_rst = 1'b0;
    step(11);
    chk("abort_e11_soc", {31'b0, bus.soc_rst}, 32'd1);
    step(1);
    chk("abort_e12_soc",   {31'b0, bus.soc_rst}, 32'd0);
    chk("abort_e12_count", {30'b0, bus.rst_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
